call_frame_stack: RTL and testbench
===================================

Name: call_frame_stack

Overview:
- Hardware call stack for the WebAssembly CPU core.
- Holds return frames for nested `call`, `return` and tail-call operations.
- Each frame is stored on call and restored on return. A frame is the return pc, the operand-stack base index and the result arity.
- Sits beside the operand stack inside cpu. Generalises fixed single-level call handling to a configurable depth, with overflow/underflow trapping and a tail-call replace mode.

Parameters:
- MEM_DEPTH, 6, pc width is MEM_DEPTH+1 bits.
- STACK_DEPTH, 7, operand-stack index width is STACK_DEPTH+1 bits.
- CALL_DEPTH, 4, log2 of frame capacity (2**CALL_DEPTH entries).
- TRAP_OVERFLOW, 4'hA, trap code on push while full.
- TRAP_UNDERFLOW, 4'hB, trap code on pop/replace while empty.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous clear to empty, also clears trap.
- push  input  1  call: store a new frame.
- pop  input  1  return: discard the top frame.
- in_pc  input  MEM_DEPTH+1  return pc of the frame being pushed.
- in_index  input  STACK_DEPTH+1  operand-stack base of the frame being pushed.
- in_arity  input  1  result count of the callee (0 or 1).
- top_pc  output  MEM_DEPTH+1  return pc of the top frame.
- top_index  output  STACK_DEPTH+1  base index of the top frame.
- top_arity  output  1  arity of the top frame.
- depth  output  CALL_DEPTH+1  number of valid frames.
- empty  output  1  depth==0.
- full  output  1  depth==2**CALL_DEPTH.
- trap  output  4  0 = none, else the sticky trap code.

Behaviour:
- Storage:
  - Register array of 2**CALL_DEPTH entries, each MEM_DEPTH+1+STACK_DEPTH+1+1 bits wide.
  - Write pointer equals depth.
- Reset (async, effective immediately):
  - depth=0, empty=1, full=0, trap=0.
  - top_pc=0, top_index=0, top_arity=0.
  - Array contents are don't-care.
- FSM states: RUN and TRAPPED. Reset enters RUN.
- Priority each cycle: flush > (push&pop) > push > pop.
  - flush: depth←0, trap←0, state←RUN. Any push/pop in the same cycle is ignored.
  - push only, not full: mem[depth]←{in_pc,in_index,in_arity}, depth←depth+1.
  - push only, full: no write, depth unchanged, trap←TRAP_OVERFLOW, state←TRAPPED.
  - pop only, not empty: depth←depth−1; the entry is left in place.
  - pop only, empty: trap←TRAP_UNDERFLOW, state←TRAPPED.
  - push&pop (tail call), not empty: mem[depth−1]←inputs, depth unchanged. Legal when full.
  - push&pop, empty: trap←TRAP_UNDERFLOW, state←TRAPPED.
- TRAPPED state:
  - push and pop are ignored; depth, array and top_* hold.
  - trap holds its code until flush or reset.
  - The first trap wins; no later code overwrites it.
- Outputs:
  - top_*, depth, empty, full and trap are all registered.
  - The effect of an operation sampled at edge N is visible after edge N (one-cycle latency).
  - A result is never combinational from push/pop.
  - top_* reflect mem[depth−1] after the update.
  - When depth becomes 0, top_* go to 0.
  - Tail call: top_* show the new inputs the next cycle.
  - Push followed by pop: top_* return to the previous frame's exact values.
- Arithmetic:
  - depth never wraps; the saturation cases are the trap cases above.
  - Push-to-full then pop-to-empty takes exactly 2**CALL_DEPTH operations each way.
- Mid-operation reset: an asserted reset overrides all inputs and clears within the same cycle, regardless of clock.

Test Plan:
- Reset then idle → depth=0, empty=1, trap=0, top_pc=0.
- push (in_pc=33, in_index=5, in_arity=1), then pop → after push: top_pc=33, top_index=5, top_arity=1, depth=1. After pop: depth=0, empty=1, top_*=0.
- Nested: push pc=10, 20, 30 (index=1, 2, 3), then 3 pops → top_pc sequence 30, 20, 10, then empty. depth sequence 3, 2, 1, 0.
- Fill 16 frames (CALL_DEPTH=4), then a 17th push → full=1 after the 16th push. After the 17th: trap=4'hA, depth=16, top_pc still the 16th value. A subsequent pop is ignored (depth=16).
- pop on empty → trap=4'hB. Then flush → trap=0, depth=0. Then push pc=7 succeeds (top_pc=7).
- Tail call: push pc=12, then push&pop with pc=40, index=9 → depth stays 1, top_pc=40, top_index=9. Repeat at full=1: no trap. Assert reset asynchronously mid-sequence between edges → all outputs 0 immediately.

Source files
------------

// File: rtl/call_frame_stack.sv
// call_frame_stack
//   Hardware call stack for the WebAssembly core. Each frame is a return
//   pc, the operand-stack base index and the callee's result arity. Frames
//   are stored by `call` (push), discarded by `return` (pop), and replaced
//   in place by a tail call (push and pop together). Overflow and underflow
//   raise a sticky trap code that freezes the stack until flush or reset.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   flush      synchronous clear to empty; also clears the trap
//   push       call: store a new frame
//   pop        return: discard the top frame
//   in_pc      return pc of the frame being pushed
//   in_index   operand-stack base of the frame being pushed
//   in_arity   result count of the callee (0 or 1)
//   top_pc     return pc of the top frame (0 when empty)
//   top_index  base index of the top frame (0 when empty)
//   top_arity  arity of the top frame (0 when empty)
//   depth      number of valid frames
//   empty      depth == 0
//   full       depth == 2**CALL_DEPTH
//   trap       0 = none, otherwise the first trap code raised
//
// All outputs are registered: an operation sampled at edge N is visible
// just after edge N.
module call_frame_stack #(
  parameter int         MEM_DEPTH      = 6,
  parameter int         STACK_DEPTH    = 7,
  parameter int         CALL_DEPTH     = 4,
  parameter logic [3:0] TRAP_OVERFLOW  = 4'hA,
  parameter logic [3:0] TRAP_UNDERFLOW = 4'hB
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [MEM_DEPTH:0]     in_pc,
  input  logic [STACK_DEPTH:0]   in_index,
  input  logic                   in_arity,
  output logic [MEM_DEPTH:0]     top_pc,
  output logic [STACK_DEPTH:0]   top_index,
  output logic                   top_arity,
  output logic [CALL_DEPTH:0]    depth,
  output logic                   empty,
  output logic                   full,
  output logic [3:0]             trap
);

  typedef struct packed {
    logic [MEM_DEPTH:0]   pc;
    logic [STACK_DEPTH:0] index;
    logic                 arity;
  } frame_t;

  typedef enum logic {RUN, TRAPPED} state_t;

  localparam logic [CALL_DEPTH:0] ONE        = {{CALL_DEPTH{1'b0}}, 1'b1};
  localparam logic [CALL_DEPTH:0] FULL_COUNT = {1'b1, {CALL_DEPTH{1'b0}}};

  frame_t mem [2**CALL_DEPTH];

  state_t                state_q, state_d;
  logic [CALL_DEPTH:0]   depth_q, depth_d;
  logic [3:0]            trap_q, trap_d;
  frame_t                top_q, top_d;
  logic                  empty_q, full_q;

  logic                  wr_en;
  logic [CALL_DEPTH-1:0] wr_addr;
  frame_t                wr_data;
  frame_t                in_frame;
  logic [CALL_DEPTH:0]   depth_m1, depth_m2;

  assign in_frame = '{pc: in_pc, index: in_index, arity: in_arity};
  assign depth_m1 = depth_q - ONE;
  assign depth_m2 = depth_q - ONE - ONE;

  // Next-state and datapath control. Priority: flush > tail call > push > pop.
  // NOTE: every variable is given a default first so no path leaves it
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    state_d = state_q;
    depth_d = depth_q;
    trap_d  = trap_q;
    top_d   = top_q;
    wr_en   = 1'b0;
    wr_addr = depth_q[CALL_DEPTH-1:0];
    wr_data = in_frame;

    if (flush) begin
      state_d = RUN;
      depth_d = '0;
      trap_d  = '0;
      top_d   = '0;
    end else if (state_q == RUN) begin
      if (push && pop) begin
        // Tail call overwrites the top frame in place; legal even when full.
        if (empty_q) begin
          trap_d  = TRAP_UNDERFLOW;
          state_d = TRAPPED;
        end else begin
          wr_en   = 1'b1;
          wr_addr = depth_m1[CALL_DEPTH-1:0];
          top_d   = in_frame;
        end
      end else if (push) begin
        if (full_q) begin
          trap_d  = TRAP_OVERFLOW;
          state_d = TRAPPED;
        end else begin
          wr_en   = 1'b1;
          depth_d = depth_q + ONE;
          top_d   = in_frame;
        end
      end else if (pop) begin
        if (empty_q) begin
          trap_d  = TRAP_UNDERFLOW;
          state_d = TRAPPED;
        end else begin
          // The popped entry stays in the array; the new top is the one below.
          depth_d = depth_m1;
          top_d   = (depth_m1 == '0) ? frame_t'('0) : mem[depth_m2[CALL_DEPTH-1:0]];
        end
      end
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      depth_q <= '0;
      trap_q  <= '0;
      top_q   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
      trap_q  <= trap_d;
      top_q   <= top_d;
      empty_q <= (depth_d == '0);
      full_q  <= (depth_d == FULL_COUNT);
    end
  end

  // NOTE: the frame array has no reset; entries above depth are never read,
  // so leaving them unreset keeps it a plain register file.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign top_pc    = top_q.pc;
  assign top_index = top_q.index;
  assign top_arity = top_q.arity;
  assign depth     = depth_q;
  assign empty     = empty_q;
  assign full      = full_q;
  assign trap      = trap_q;

endmodule

// File: tb/tb_call_frame_stack.sv
// Bench for call_frame_stack: a driver applies directed and random
// operations, steps a queue-based reference stack and pushes the expected
// post-edge outputs into a scoreboard; an independent monitor pops and
// compares one entry after each rising edge.
module tb_call_frame_stack;

  localparam int MEM_DEPTH   = 6;
  localparam int STACK_DEPTH = 7;
  localparam int CALL_DEPTH  = 4;
  localparam int CAP         = 2**CALL_DEPTH;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 flush = 1'b0, push = 1'b0, pop = 1'b0;
  logic [MEM_DEPTH:0]   in_pc = '0;
  logic [STACK_DEPTH:0] in_index = '0;
  logic                 in_arity = 1'b0;
  logic [MEM_DEPTH:0]   top_pc;
  logic [STACK_DEPTH:0] top_index;
  logic                 top_arity;
  logic [CALL_DEPTH:0]  depth;
  logic                 empty, full;
  logic [3:0]           trap;

  call_frame_stack #(
    .MEM_DEPTH(MEM_DEPTH), .STACK_DEPTH(STACK_DEPTH), .CALL_DEPTH(CALL_DEPTH),
    .TRAP_OVERFLOW(4'hA), .TRAP_UNDERFLOW(4'hB)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush), .push(push), .pop(pop),
    .in_pc(in_pc), .in_index(in_index), .in_arity(in_arity),
    .top_pc(top_pc), .top_index(top_index), .top_arity(top_arity),
    .depth(depth), .empty(empty), .full(full), .trap(trap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [MEM_DEPTH:0]   pc;
    logic [STACK_DEPTH:0] idx;
    logic                 ar;
  } frame_t;

  typedef struct {
    string                tag;
    logic [MEM_DEPTH:0]   pc;
    logic [STACK_DEPTH:0] idx;
    logic                 ar;
    logic [CALL_DEPTH:0]  depth;
    logic                 empty;
    logic                 full;
    logic [3:0]           trap;
  } snap_t;

  frame_t     stack_m[$];
  logic [3:0] trap_m = 4'h0;
  snap_t      exp_q[$];
  snap_t      e;
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: a queue of frames plus a trap code; nonzero trap = frozen.
  task automatic model_step(input logic f, input logic p, input logic q, input frame_t fr);
    if (f) begin
      stack_m.delete();
      trap_m = 4'h0;
    end else if (trap_m != 4'h0) begin
      // frozen until flush
    end else if (p && q) begin
      if (stack_m.size() == 0) trap_m = 4'hB;
      else begin
        void'(stack_m.pop_back());
        stack_m.push_back(fr);
      end
    end else if (p) begin
      if (stack_m.size() == CAP) trap_m = 4'hA;
      else stack_m.push_back(fr);
    end else if (q) begin
      if (stack_m.size() == 0) trap_m = 4'hB;
      else void'(stack_m.pop_back());
    end
  endtask

  task automatic op(input logic f, input logic p, input logic q,
                    input int pc, input int idx, input logic ar, input string tag);
    frame_t fr;
    snap_t  s;
    @(negedge clk);
    flush    = f;
    push     = p;
    pop      = q;
    in_pc    = pc[MEM_DEPTH:0];
    in_index = idx[STACK_DEPTH:0];
    in_arity = ar;
    fr.pc  = pc[MEM_DEPTH:0];
    fr.idx = idx[STACK_DEPTH:0];
    fr.ar  = ar;
    model_step(f, p, q, fr);
    s.tag = tag;
    if (stack_m.size() > 0) begin
      s.pc  = stack_m[stack_m.size()-1].pc;
      s.idx = stack_m[stack_m.size()-1].idx;
      s.ar  = stack_m[stack_m.size()-1].ar;
    end else begin
      s.pc  = '0;
      s.idx = '0;
      s.ar  = 1'b0;
    end
    s.depth = (CALL_DEPTH+1)'(stack_m.size());
    s.empty = (stack_m.size() == 0);
    s.full  = (stack_m.size() == CAP);
    s.trap  = trap_m;
    exp_q.push_back(s);
  endtask

  task automatic idle(input string tag);
    op(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, tag);
  endtask

  task automatic do_push(input int pc, input int idx, input logic ar, input string tag);
    op(1'b0, 1'b1, 1'b0, pc, idx, ar, tag);
  endtask

  task automatic do_pop(input string tag);
    op(1'b0, 1'b0, 1'b1, 0, 0, 1'b0, tag);
  endtask

  task automatic do_tail(input int pc, input int idx, input logic ar, input string tag);
    op(1'b0, 1'b1, 1'b1, pc, idx, ar, tag);
  endtask

  task automatic do_flush(input string tag);
    op(1'b1, 1'b0, 1'b0, 0, 0, 1'b0, tag);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_depth"}, 32'(depth), 32'd0);
    check({tag, "_empty"}, 32'(empty), 32'd1);
    check({tag, "_full"},  32'(full),  32'd0);
    check({tag, "_trap"},  32'(trap),  32'd0);
    check({tag, "_pc"},    32'(top_pc),    32'd0);
    check({tag, "_index"}, 32'(top_index), 32'd0);
    check({tag, "_arity"}, 32'(top_arity), 32'd0);
  endtask

  // Reset asserted between edges must clear outputs without waiting for a clock.
  task automatic async_reset(input string tag);
    @(posedge clk);
    #3;
    reset = 1'b1;
    flush = 1'b0;
    push  = 1'b0;
    pop   = 1'b0;
    #1;
    check_cleared(tag);
    stack_m.delete();
    trap_m = 4'h0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: one scoreboard entry per sampled edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!reset && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (top_pc !== e.pc || top_index !== e.idx || top_arity !== e.ar ||
            depth !== e.depth || empty !== e.empty || full !== e.full || trap !== e.trap) begin
          errors++;
          $display("FAIL %s: got pc=%0d idx=%0d ar=%0b depth=%0d empty=%0b full=%0b trap=%h expected pc=%0d idx=%0d ar=%0b depth=%0d empty=%0b full=%0b trap=%h",
                   e.tag, top_pc, top_index, top_arity, depth, empty, full, trap,
                   e.pc, e.idx, e.ar, e.depth, e.empty, e.full, e.trap);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r;
    repeat (3) @(posedge clk);
    #1;
    check_cleared("reset");
    @(negedge clk);
    reset = 1'b0;

    idle("idle");

    do_push(33, 5, 1'b1, "push33");
    do_pop("pop33");

    do_push(10, 1, 1'b0, "nest10");
    do_push(20, 2, 1'b1, "nest20");
    do_push(30, 3, 1'b0, "nest30");
    repeat (3) do_pop("nest_pop");

    for (int i = 0; i < CAP; i++) do_push(50 + i, i, i[0], "fill");
    do_push(99, 99, 1'b1, "overflow");
    do_pop("pop_when_trapped");
    do_tail(98, 98, 1'b0, "tail_when_trapped");

    do_flush("flush1");
    do_pop("underflow");
    do_push(5, 5, 1'b1, "push_when_trapped");
    do_flush("flush2");
    do_push(7, 4, 1'b0, "push7");

    do_flush("flush3");
    do_push(12, 3, 1'b0, "push12");
    do_tail(40, 9, 1'b1, "tail40");
    do_pop("tail_pop");
    do_tail(41, 2, 1'b0, "tail_empty");
    do_flush("flush4");
    for (int i = 0; i < CAP; i++) do_push(70 + i, 100 + i, ~i[0], "fill2");
    do_tail(100, 77, 1'b1, "tail_full");
    do_pop("pop_after_tail_full");
    do_pop("pop_after_tail_full2");
    do_push(3, 3, 1'b1, "push_mid");
    async_reset("async_reset1");

    idle("post_reset_idle");
    do_push(9, 8, 1'b1, "post_reset_push");

    for (int n = 0; n < 500; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 40)      do_push(int'($urandom_range(0, 127)), int'($urandom_range(0, 255)), 1'($urandom), "rand_push");
      else if (r < 65) do_pop("rand_pop");
      else if (r < 80) do_tail(int'($urandom_range(0, 127)), int'($urandom_range(0, 255)), 1'($urandom), "rand_tail");
      else if (r < 84) do_flush("rand_flush");
      else             idle("rand_idle");
    end
    async_reset("async_reset2");

    idle("final_idle");
    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
